// File: rtl/sdram_tg_pkg.sv
// Shared types and helpers for the SDRAM traffic generator.
// State/pattern enums, mode encodings and the Galois LFSR step.
package sdram_tg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_ACK,
    S_RD_REQ,
    S_RD_ACK,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR,
    PAT_INV,
    PAT_WALK,
    PAT_LFSR
  } pattern_e;

  localparam logic MODE_INTERLEAVED = 1'b0;
  localparam logic MODE_SEQUENTIAL  = 1'b1;

  // Right-shifting Galois step; state is zero-extended above width.
  function automatic logic [63:0] lfsr_next(
    input logic [63:0] s,
    input int unsigned width
  );
    logic [63:0] taps;
    logic [63:0] n;
    unique case (width)
      16:      taps = 64'h0000_0000_0000_B400;
      64:      taps = 64'hD800_0000_0000_0000;
      default: taps = 64'h0000_0000_8020_0003;
    endcase
    n = s >> 1;
    if (s[0]) n = n ^ taps;
    return n;
  endfunction

endpackage

// File: rtl/sdram_tg_patgen.sv
// Data pattern generator: maps word index, address and LFSR
// state onto the selected test pattern.
import sdram_tg_pkg::*;

module sdram_tg_patgen #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 16
) (
  input  logic [COUNT_W-1:0] idx_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  lfsr_i,
  input  pattern_e           pattern_i,
  output logic [DATA_W-1:0]  data_o
);

  localparam logic [COUNT_W-1:0] DW = COUNT_W'(DATA_W);

  logic [ADDR_W+DATA_W-1:0] addr_wide;
  logic [DATA_W-1:0]        addr_data;
  logic [DATA_W-1:0]        walk;

  assign addr_wide = {{DATA_W{1'b0}}, addr_i};
  assign addr_data = addr_wide[DATA_W-1:0];
  assign walk      = DATA_W'(1) << (idx_i % DW);

  always_comb begin
    data_o = addr_data;
    unique case (1'b1)
      pattern_i == PAT_ADDR: data_o = addr_data;
      pattern_i == PAT_INV:  data_o = ~addr_data;
      pattern_i == PAT_WALK: data_o = walk;
      pattern_i == PAT_LFSR: data_o = lfsr_i;
      default:               data_o = addr_data;
    endcase
  end

endmodule

// File: rtl/sdram_traffic_gen.sv
// SDRAM host-port traffic generator and read-back checker.
// Issues write/read runs, compares reads and reports results.
import sdram_tg_pkg::*;

module sdram_traffic_gen #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 16,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [1:0]          pattern_i,
  input  logic [ADDR_W-1:0]   base_i,
  input  logic [COUNT_W-1:0]  count_i,
  input  logic [DATA_W-1:0]   seed_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic [ERR_W-1:0]    err_count_o,
  output logic [ADDR_W-1:0]   fail_addr_o,
  output logic [DATA_W-1:0]   fail_data_o,
  output logic [ADDR_W-1:0]   core_addr_o,
  output logic [DATA_W-1:0]   core_write_data_o,
  output logic [DATA_W/8-1:0] core_wr_o,
  output logic                core_rd_o,
  input  logic                core_accept_i,
  input  logic                core_ack_i,
  input  logic                core_error_i,
  input  logic [DATA_W-1:0]   core_read_data_i
);

  localparam int BYTES = DATA_W / 8;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LOW = ADDR_W'(BYTES - 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  state_e state_q, state_d, wr_next, rd_next;

  logic                mode_q;
  pattern_e            pat_q;
  logic [ADDR_W-1:0]   base_q;
  logic [COUNT_W-1:0]  count_q, idx_q;
  logic [DATA_W-1:0]   seed_q, wlfsr_q, rlfsr_q;
  logic [WD_W-1:0]     wd_q;
  logic [ERR_W-1:0]    err_q;
  logic                failed_q, timeout_q;
  logic [ADDR_W-1:0]   fail_addr_q, addr_q;
  logic [DATA_W-1:0]   fail_data_q, wdata_q;
  logic [BYTES-1:0]    wr_q;
  logic                rd_q;

  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   wdata, exp_data, seed_eff;
  logic                in_req, in_ack, in_wr, req_q;
  logic                start_ok, issue, acc_ev, ack_ev;
  logic                wr_done, rd_done, last, to_hit;
  logic                err_ev, wd_clr;

  assign seed_eff = (seed_i == '0) ? '1 : seed_i;
  assign cur_addr = base_q + ADDR_W'(idx_q) * ADDR_W'(BYTES);

  assign in_req = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign in_ack = (state_q == S_WR_ACK) || (state_q == S_RD_ACK);
  assign in_wr  = (state_q == S_WR_REQ) || (state_q == S_WR_ACK);
  assign req_q  = rd_q || (wr_q != '0);

  assign start_ok = start_i &&
    ((state_q == S_IDLE) || (state_q == S_DONE));
  assign issue   = in_req && !req_q;
  assign acc_ev  = in_req && req_q && core_accept_i;
  assign ack_ev  = (acc_ev && core_ack_i) || (in_ack && core_ack_i);
  assign wr_done = ack_ev && in_wr;
  assign rd_done = ack_ev && !in_wr;
  assign last    = idx_q == count_q - COUNT_W'(1);
  // Progress in the same cycle wins over the watchdog.
  assign to_hit  = (in_req || in_ack) && (wd_q == WD_MAX) &&
                   !acc_ev && !ack_ev;
  assign err_ev  = (wr_done && core_error_i) ||
    (rd_done && (core_error_i || core_read_data_i != exp_data));
  assign wd_clr  = (state_d != state_q) || acc_ev || ack_ev;

  sdram_tg_patgen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .COUNT_W(COUNT_W)
  ) u_wr_pat (
    .idx_i    (idx_q),
    .addr_i   (cur_addr),
    .lfsr_i   (wlfsr_q),
    .pattern_i(pat_q),
    .data_o   (wdata)
  );

  sdram_tg_patgen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .COUNT_W(COUNT_W)
  ) u_exp_pat (
    .idx_i    (idx_q),
    .addr_i   (cur_addr),
    .lfsr_i   (rlfsr_q),
    .pattern_i(pat_q),
    .data_o   (exp_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    wr_next = (mode_q == MODE_SEQUENTIAL && !last) ? S_WR_REQ : S_RD_REQ;
    rd_next = last ? S_DONE :
      ((mode_q == MODE_SEQUENTIAL) ? S_RD_REQ : S_WR_REQ);
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE:
        if (start_i) state_d = (count_i == '0) ? S_DONE : S_WR_REQ;
      S_WR_REQ:
        if (acc_ev) state_d = core_ack_i ? wr_next : S_WR_ACK;
      S_WR_ACK:
        if (ack_ev) state_d = wr_next;
      S_RD_REQ:
        if (acc_ev) state_d = core_ack_i ? rd_next : S_RD_ACK;
      S_RD_ACK:
        if (ack_ev) state_d = rd_next;
      default: state_d = S_IDLE;
    endcase
    if (to_hit) state_d = S_DONE;
  end

  always_comb begin
    busy_o = in_req || in_ack;
    done_o = state_q == S_DONE;
    pass_o = done_o && (err_q == '0) && !timeout_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q      <= MODE_INTERLEAVED;
      pat_q       <= PAT_ADDR;
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      seed_q      <= '0;
      wlfsr_q     <= '0;
      rlfsr_q     <= '0;
      wd_q        <= '0;
      err_q       <= '0;
      failed_q    <= 1'b0;
      timeout_q   <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= '0;
      rd_q        <= 1'b0;
    end else begin
      if (wd_clr)      wd_q <= '0;
      else if (busy_o) wd_q <= wd_q + WD_W'(1);
      if (start_ok) begin
        mode_q      <= mode_i;
        pat_q       <= pattern_e'(pattern_i);
        base_q      <= base_i & ~LOW;
        count_q     <= count_i;
        idx_q       <= '0;
        seed_q      <= seed_eff;
        wlfsr_q     <= seed_eff;
        rlfsr_q     <= seed_eff;
        err_q       <= '0;
        failed_q    <= 1'b0;
        timeout_q   <= 1'b0;
        fail_addr_q <= '0;
        fail_data_q <= '0;
      end
      if (issue) begin
        addr_q <= cur_addr;
        if (in_wr) begin
          wr_q    <= '1;
          wdata_q <= wdata;
        end else begin
          rd_q <= 1'b1;
        end
      end
      if (acc_ev) begin
        wr_q <= '0;
        rd_q <= 1'b0;
      end
      if (wr_done) begin
        wlfsr_q <= DATA_W'(lfsr_next(64'(wlfsr_q), DATA_W));
        if (mode_q == MODE_SEQUENTIAL) begin
          // Rewind for the read pass after the last write.
          if (last) begin
            idx_q   <= '0;
            rlfsr_q <= seed_q;
          end else begin
            idx_q <= idx_q + COUNT_W'(1);
          end
        end
      end
      if (rd_done) begin
        rlfsr_q <= DATA_W'(lfsr_next(64'(rlfsr_q), DATA_W));
        idx_q   <= idx_q + COUNT_W'(1);
      end
      if (err_ev) begin
        if (~&err_q) err_q <= err_q + ERR_W'(1);
        if (!failed_q) begin
          failed_q    <= 1'b1;
          fail_addr_q <= cur_addr;
          fail_data_q <= wr_done ? wdata_q : core_read_data_i;
        end
      end
      if (to_hit) begin
        timeout_q <= 1'b1;
        wr_q      <= '0;
        rd_q      <= 1'b0;
      end
    end
  end

  assign timeout_o         = timeout_q;
  assign err_count_o       = err_q;
  assign fail_addr_o       = fail_addr_q;
  assign fail_data_o       = fail_data_q;
  assign core_addr_o       = addr_q;
  assign core_write_data_o = wdata_q;
  assign core_wr_o         = wr_q;
  assign core_rd_o         = rd_q;

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Directed bench for sdram_traffic_gen: run table against a
// behavioural memory plus reset/start corner sequences.
module tb_sdram_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  pat = 2'd0;
  logic [31:0] base = '0;
  logic [15:0] count = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass, tmo;
  logic [15:0] errc;
  logic [31:0] faddr, fdata, caddr, cwdata, crdata;
  logic [3:0]  cwr;
  logic        crd, cacc, cack, cerr;

  always #5 clk = ~clk;

  sdram_traffic_gen #(
    .ADDR_W(32), .DATA_W(32), .COUNT_W(16),
    .ERR_W(16), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .mode_i(mode), .pattern_i(pat), .base_i(base),
    .count_i(count), .seed_i(seed),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .timeout_o(tmo), .err_count_o(errc),
    .fail_addr_o(faddr), .fail_data_o(fdata),
    .core_addr_o(caddr), .core_write_data_o(cwdata),
    .core_wr_o(cwr), .core_rd_o(crd),
    .core_accept_i(cacc), .core_ack_i(cack),
    .core_error_i(cerr), .core_read_data_i(crdata)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Responder with programmable accept delay, ack drop and bit flip.
  int acc_delay = 0;
  bit no_ack = 1'b0;
  bit corrupt = 1'b0;
  int wait_cnt = 0;
  logic req;
  logic [31:0] mem [0:1023];

  assign req    = crd || (cwr != 4'h0);
  assign cacc   = req && (wait_cnt >= acc_delay);
  assign cack   = cacc && !no_ack;
  assign cerr   = 1'b0;
  assign crdata = mem[caddr[11:2]] ^
    ((corrupt && caddr == 32'h1008) ? 32'h8 : 32'h0);

  logic [32:0] ops[$];
  int stalls = 0, unstable = 0, nodrop = 0;
  logic prev_req = 1'b0, prev_acc = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  logic [3:0] prev_wr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (req && !cacc) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) begin
    if (cacc) begin
      if (cwr != 4'h0) mem[caddr[11:2]] <= cwdata;
      ops.push_back({crd, caddr});
    end
    if (req && !cacc) stalls <= stalls + 1;
    if (req && prev_req && !prev_acc &&
        (caddr != prev_addr || cwdata != prev_data || cwr != prev_wr))
      unstable <= unstable + 1;
    if (req && prev_req && prev_acc) nodrop <= nodrop + 1;
    prev_req  <= req;
    prev_acc  <= cacc;
    prev_addr <= caddr;
    prev_data <= cwdata;
    prev_wr   <= cwr;
  end

  typedef struct {
    logic [31:0] base;
    logic [15:0] count;
    bit          mode;
    logic [1:0]  pat;
    logic [31:0] seed;
    int          delay;
    bit          noack;
    bit          corrupt;
    bit          e_pass;
    int          e_err;
    bit          e_to;
    int          e_ops;
    logic [31:0] e_first;
    logic [31:0] e_faddr;
    logic [31:0] e_fdata;
    int          order;
    bit          chk_mem;
    logic [31:0] m0;
    logic [31:0] m1;
  } run_t;

  run_t runs[8];

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  initial begin
    int o0, s0, cyc, bad, k;
    logic [32:0] op;
    logic [31:0] ea;
    logic [9:0] mi;

    runs[0] = '{32'h1000, 16'd10, 1'b0, 2'd0, 32'h0, 0, 1'b0,
      1'b0, 1'b1, 0, 1'b0, 20, 32'h1000, 32'h0, 32'h0, 1, 1'b1,
      32'h1000, 32'h1004};
    runs[1] = '{32'h1000, 16'd256, 1'b1, 2'd3, 32'hACE1, 0, 1'b0,
      1'b0, 1'b1, 0, 1'b0, 512, 32'h1000, 32'h0, 32'h0, 2, 1'b1,
      32'h0000ACE1, 32'h80205673};
    runs[2] = '{32'h1000, 16'd16, 1'b1, 2'd3, 32'h0, 0, 1'b0,
      1'b0, 1'b1, 0, 1'b0, 32, 32'h1000, 32'h0, 32'h0, 2, 1'b1,
      32'hFFFFFFFF, 32'hFFDFFFFC};
    runs[3] = '{32'h1000, 16'd8, 1'b0, 2'd2, 32'h0, 0, 1'b0,
      1'b1, 1'b0, 1, 1'b0, 16, 32'h1000, 32'h1008, 32'h0000000C,
      1, 1'b1, 32'h1, 32'h2};
    runs[4] = '{32'h2000, 16'd4, 1'b0, 2'd1, 32'h0, 5, 1'b0,
      1'b0, 1'b1, 0, 1'b0, 8, 32'h2000, 32'h0, 32'h0, 1, 1'b1,
      32'hFFFFDFFF, 32'hFFFFDFFB};
    runs[5] = '{32'h3003, 16'd2, 1'b0, 2'd0, 32'h0, 0, 1'b0,
      1'b0, 1'b1, 0, 1'b0, 4, 32'h3000, 32'h0, 32'h0, 1, 1'b1,
      32'h3000, 32'h3004};
    runs[6] = '{32'h1000, 16'd3, 1'b0, 2'd0, 32'h0, 0, 1'b1,
      1'b0, 1'b0, 0, 1'b1, 1, 32'h1000, 32'h0, 32'h0, 0, 1'b0,
      32'h0, 32'h0};
    runs[7] = '{32'h1100, 16'd5, 1'b1, 2'd1, 32'h0, 0, 1'b0,
      1'b0, 1'b1, 0, 1'b0, 10, 32'h1100, 32'h0, 32'h0, 2, 1'b1,
      32'hFFFFEEFF, 32'hFFFFEEFB};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_req", 64'({cwr, crd}), 64'd0);
    chk("rst_addr", 64'(caddr), 64'd0);
    chk("rst_err", 64'({errc, tmo, faddr, fdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // count 0 finishes one cycle after start with pass
    count = 16'd0;
    o0 = ops.size();
    pulse_start();
    chk("cnt0_done", 64'(done), 64'd1);
    chk("cnt0_pass", 64'(pass), 64'd1);
    chk("cnt0_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("cnt0_ops", 64'(ops.size() - o0), 64'd0);

    foreach (runs[i]) begin
      @(negedge clk);
      base = runs[i].base;
      count = runs[i].count;
      mode = runs[i].mode;
      pat = runs[i].pat;
      seed = runs[i].seed;
      acc_delay = runs[i].delay;
      no_ack = runs[i].noack;
      corrupt = runs[i].corrupt;
      o0 = ops.size();
      s0 = stalls;
      pulse_start();
      wait_done(cyc);
      chk($sformatf("r%0d_done", i), 64'(done), 64'd1);
      chk($sformatf("r%0d_pass", i), 64'(pass), 64'(runs[i].e_pass));
      chk($sformatf("r%0d_err", i), 64'(errc), 64'(runs[i].e_err));
      chk($sformatf("r%0d_tmo", i), 64'(tmo), 64'(runs[i].e_to));
      chk($sformatf("r%0d_ops", i), 64'(ops.size() - o0),
          64'(runs[i].e_ops));
      op = ops[o0];
      chk($sformatf("r%0d_first", i), 64'(op[31:0]),
          64'(runs[i].e_first));
      chk($sformatf("r%0d_idle_req", i), 64'({cwr, crd, busy}), 64'd0);
      if (runs[i].e_err != 0) begin
        chk($sformatf("r%0d_faddr", i), 64'(faddr),
            64'(runs[i].e_faddr));
        chk($sformatf("r%0d_fdata", i), 64'(fdata),
            64'(runs[i].e_fdata));
      end
      if (runs[i].delay != 0)
        chk($sformatf("r%0d_stalls", i), 64'(stalls - s0),
            64'(runs[i].delay * runs[i].e_ops));
      if (runs[i].noack)
        chk($sformatf("r%0d_tmo_lat", i),
            64'(cyc >= 16 && cyc <= 20), 64'd1);
      if (runs[i].order != 0) begin
        bad = 0;
        for (int j = 0; j < runs[i].e_ops; j++) begin
          op = ops[o0 + j];
          if (runs[i].order == 1) begin
            k = j / 2;
            ea = runs[i].e_first + 32'(4 * k);
            if (op[32] != 1'(j % 2) || op[31:0] != ea) bad++;
          end else begin
            k = (j < int'(runs[i].count)) ? j : j - int'(runs[i].count);
            ea = runs[i].e_first + 32'(4 * k);
            if (op[32] != (j >= int'(runs[i].count)) || op[31:0] != ea)
              bad++;
          end
        end
        chk($sformatf("r%0d_order", i), 64'(bad), 64'd0);
      end
      if (runs[i].chk_mem) begin
        mi = runs[i].e_first[11:2];
        chk($sformatf("r%0d_mem0", i), 64'(mem[mi]), 64'(runs[i].m0));
        chk($sformatf("r%0d_mem1", i), 64'(mem[mi + 10'd1]),
            64'(runs[i].m1));
      end
    end
    chk("req_stable", 64'(unstable), 64'd0);
    chk("req_drop", 64'(nodrop), 64'd0);

    // start while busy must not restart the run
    @(negedge clk);
    base = 32'h1000; count = 16'd4; mode = 1'b0; pat = 2'd0;
    acc_delay = 3; no_ack = 1'b0; corrupt = 1'b0;
    o0 = ops.size();
    pulse_start();
    repeat (6) @(posedge clk);
    @(negedge clk);
    base = 32'h2000; count = 16'd1;
    pulse_start();
    wait_done(cyc);
    chk("busy_start_ops", 64'(ops.size() - o0), 64'd8);
    op = ops[ops.size() - 1];
    chk("busy_start_last", 64'(op), 64'h1_0000_100C);
    chk("busy_start_pass", 64'(pass), 64'd1);

    // asynchronous reset mid-run
    @(negedge clk);
    base = 32'h1000; count = 16'd20; acc_delay = 0;
    pulse_start();
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_req", 64'({cwr, crd}), 64'd0);
    chk("arst_addr", 64'({caddr, cwdata}), 64'd0);
    o0 = ops.size();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("arst_idle", 64'({busy, done, cwr, crd}), 64'd0);
    chk("arst_no_ops", 64'(ops.size() - o0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
